// File: rtl/pipelined_adder.sv
// Pipelined add/subtract, one CHUNK-bit slice per stage, with a global stall under backpressure.
// Skew registers shift the unused upper operand slices forward; deskew registers grow the finished sum.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    assign b_eff    = sub ? ~b : b;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRCW = WIDTH - k * CHUNK;
        localparam int ACCW = (k + 1) * CHUNK;

        logic [SRCW-1:0]  src_a;
        logic [SRCW-1:0]  src_b;
        logic             src_c;
        logic             src_v;
        logic [CHUNK:0]   part;
        logic [ACCW-1:0]  acc_d;
        logic [ACCW-1:0]  acc_q;
        logic             vld_q;
        logic             cy_q;

        if (k == 0) begin : g_in
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = cin ^ sub;
            assign src_v = in_valid;
            assign acc_d = part[CHUNK-1:0];
        end else begin : g_link
            assign src_a = g_stage[k-1].g_skew.rem_a;
            assign src_b = g_stage[k-1].g_skew.rem_b;
            assign src_c = g_stage[k-1].cy_q;
            assign src_v = g_stage[k-1].vld_q;
            // The new slice lands above the slices already completed upstream.
            assign acc_d = {part[CHUNK-1:0], g_stage[k-1].acc_q};
        end

        assign part = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                    + (CHUNK + 1)'(src_c);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                acc_q <= '0;
            end else if (advance) begin
                vld_q <= src_v;
                cy_q  <= part[CHUNK];
                acc_q <= acc_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [SRCW-CHUNK-1:0] rem_a;
            logic [SRCW-CHUNK-1:0] rem_b;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rem_a <= '0;
                    rem_b <= '0;
                end else if (advance) begin
                    rem_a <= src_a[SRCW-1:CHUNK];
                    rem_b <= src_b[SRCW-1:CHUNK];
                end
            end
        end else begin : g_out
            logic ovf_q;

            // Only the final stage sees the operand sign bits and the result sign bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (src_a[SRCW-1] == src_b[SRCW-1])
                          && (part[CHUNK-1] != src_a[SRCW-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].acc_q;
    assign cout      = g_stage[STAGES-1].cy_q;
    assign ovf       = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors, streaming with backpressure, bubbles, mid-flight reset
// and random traffic, all against an arithmetic reference fed through an ideal stalled delay line.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic m_v [S];
    res_t m_r [S];
    logic exp_rdy;
    logic obs_rdy;
    int   n_acc = 0;
    int   n_out = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        res_t         r;
        logic [W-1:0] be;
        int unsigned  cy;
        int unsigned  tot;
        int           sg;
        be  = sb ? ~y : y;
        cy  = (sb ? !ci : ci) ? 1 : 0;
        tot = 32'(x) + 32'(be) + cy;
        sg  = int'($signed(x)) + int'($signed(be)) + int'(cy);
        r.s = tot[W-1:0];
        r.c = tot[W];
        r.o = (sg > 32767) || (sg < -32768);
        return r;
    endfunction

    // Advances one clock; the reference pipe shifts only when its head is empty or being taken.
    task automatic tick();
        res_t nr;
        logic adv;
        @(negedge clk);
        adv     = !m_v[S-1] || out_ready;
        exp_rdy = adv;
        obs_rdy = in_ready;
        nr      = model(a, b, cin, sub);
        if (rst_n && adv && in_valid) n_acc++;
        if (rst_n && m_v[S-1] && out_ready) n_out++;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                m_v[i] = 1'b0;
                m_r[i] = '0;
            end
        end else if (adv) begin
            for (int i = S - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_r[i] = m_r[i-1];
            end
            m_v[0] = in_valid;
            m_r[0] = nr;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst_n     = 1'b0;
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0;
            m_r[i] = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all 0",
                     out_valid, sum, cout, ovf);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
        logic [W-1:0] vb [6] = '{16'h0002, 16'hFFFF, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
        logic         vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        res_t         ve [6] = '{{16'h0005, 1'b0, 1'b0}, {16'hFFFF, 1'b1, 1'b0},
                                 {16'h8000, 1'b0, 1'b1}, {16'hFFFE, 1'b0, 1'b0},
                                 {16'h7FFF, 1'b1, 1'b1}, {16'h000C, 1'b1, 1'b0}};
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1;
            a        = va[v];
            b        = vb[v];
            cin      = vc[v];
            sub      = vs[v];
            for (int c = 0; c < S; c++) begin
                tick();
                idle_inputs();
                n_cmp++;
                if (out_valid !== (c == S - 1)) begin
                    n_err++;
                    $display("FAIL directed_latency v%0d c%0d: got out_valid=%b, want %b",
                             v, c, out_valid, c == S - 1);
                end
            end
            n_cmp++;
            if ({sum, cout, ovf} !== ve[v]) begin
                n_err++;
                $display("FAIL directed_result v%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         v, sum, cout, ovf, ve[v].s, ve[v].c, ve[v].o);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int   acc0 = n_acc;
        int   out0 = n_out;
        res_t held;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (n_out - out0) < 8; c++) begin
            in_valid  = (n_acc - acc0) < 8;
            a         = W'($urandom());
            b         = W'($urandom());
            cin       = 1'($urandom());
            sub       = 1'($urandom());
            out_ready = !(c >= 5 && c < 8);
            if (c == 6) held = {sum, cout, ovf};
            tick();
            n_cmp++;
            if (obs_rdy !== exp_rdy || out_valid !== m_v[S-1]) begin
                n_err++;
                $display("FAIL stream_ctrl c%0d: got in_ready=%b out_valid=%b, want %b %b",
                         c, obs_rdy, out_valid, exp_rdy, m_v[S-1]);
            end
            if (m_v[S-1]) begin
                n_cmp++;
                if ({sum, cout, ovf} !== m_r[S-1]) begin
                    n_err++;
                    $display("FAIL stream_data c%0d: got %h/%b/%b, want %h/%b/%b",
                             c, sum, cout, ovf, m_r[S-1].s, m_r[S-1].c, m_r[S-1].o);
                end
            end
            if (c >= 5 && c < 8) begin
                n_cmp++;
                if (obs_rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL stream_stall_ready c%0d: got in_ready=%b, want 0", c, obs_rdy);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if ({sum, cout, ovf} !== held) begin
                    n_err++;
                    $display("FAIL stream_hold: got %h/%b/%b, want %h/%b/%b",
                             sum, cout, ovf, held.s, held.c, held.o);
                end
            end
        end
        n_cmp++;
        if ((n_out - out0) != 8) begin
            n_err++;
            $display("FAIL stream_count: got %0d results, want 8", n_out - out0);
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_bubbles();
        logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = pat[c];
            a        = W'($urandom());
            b        = W'($urandom());
            cin      = 1'($urandom());
            sub      = 1'($urandom());
            tick();
            if (c >= S - 1) begin
                n_cmp++;
                if (out_valid !== pat[c-S+1]) begin
                    n_err++;
                    $display("FAIL bubble_valid c%0d: got %b, want %b", c, out_valid, pat[c-S+1]);
                end
                if (pat[c-S+1]) begin
                    n_cmp++;
                    if ({sum, cout, ovf} !== m_r[S-1]) begin
                        n_err++;
                        $display("FAIL bubble_data c%0d: got %h, want %h", c, sum, m_r[S-1].s);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a        = W'($urandom());
            b        = W'($urandom());
            cin      = 1'($urandom());
            sub      = 1'b0;
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all 0",
                     out_valid, sum, cout, ovf);
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                a        = 16'h1234;
                b        = 16'h0F0F;
                cin      = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
            n_cmp++;
            if (out_valid !== (c == S - 1)) begin
                n_err++;
                $display("FAIL midreset_valid c%0d: got %b, want %b", c, out_valid, c == S - 1);
            end
            if (c == S - 1) begin
                n_cmp++;
                if ({sum, cout, ovf} !== {16'h2144, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL midreset_result: got %h/%b/%b, want 2144/0/0", sum, cout, ovf);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom());
            a         = W'($urandom());
            b         = W'($urandom());
            cin       = 1'($urandom());
            sub       = 1'($urandom());
            out_ready = ($urandom_range(3) != 0);
            tick();
            n_cmp++;
            if (obs_rdy !== exp_rdy || out_valid !== m_v[S-1]) begin
                n_err++;
                $display("FAIL random_ctrl c%0d: got in_ready=%b out_valid=%b, want %b %b",
                         c, obs_rdy, out_valid, exp_rdy, m_v[S-1]);
            end
            if (m_v[S-1]) begin
                n_cmp++;
                if ({sum, cout, ovf} !== m_r[S-1]) begin
                    n_err++;
                    $display("FAIL random_data c%0d: got %h/%b/%b, want %h/%b/%b",
                             c, sum, cout, ovf, m_r[S-1].s, m_r[S-1].c, m_r[S-1].o);
                end
            end
        end
        idle_inputs();
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
